kamacore_fetch_queue: RTL and testbench

Instruction fetch front end of the kamacore five-stage pipeline, placed upstream of the IF/ID pipeline register. It owns the fetch PC and issues sequential word requests to instruction memory. It buffers the in-order responses, tagged with their PC, in a small FIFO and hands them to the IF/ID boundary through a valid/ready handshake. A branch redirect flushes the queue and discards any responses still in flight from the old path.

---
 rtl/kamacore_datatypes_pkg.sv | 16 +
 rtl/kamacore_sync_fifo.sv | 68 ++++++
 rtl/kamacore_fetch_queue.sv | 110 +++++++++++
 tb/tb_kamacore_fetch_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/kamacore_datatypes_pkg.sv
// kamacore_datatypes: shared widths and the fetch queue entry type.
`default_nettype none

package kamacore_datatypes;

  localparam int CPU_WIDTH   = 32;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]   pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/kamacore_sync_fifo.sv
// kamacore_sync_fifo: DEPTH x fetch_entry_t FIFO with flush; head is the registered read entry.
`default_nettype none

module kamacore_sync_fifo
  import kamacore_datatypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  input  fetch_entry_t                   wdata_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output fetch_entry_t                   head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero before the first fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/kamacore_fetch_queue.sv
// kamacore_fetch_queue: fetch PC owner, credit-limited imem requester and PC-tagged response buffer.
`default_nettype none

module kamacore_fetch_queue
  import kamacore_datatypes::*;
#(
  parameter int                   DEPTH    = 4,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [CPU_WIDTH-1:0]   redirect_pc,
  output logic                   imem_req_valid,
  output logic [CPU_WIDTH-1:0]   imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   out_valid,
  output logic [CPU_WIDTH-1:0]   out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  input  logic                   out_ready
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = CW + 1;

  logic [CPU_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CPU_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [DW-1:0]        discard_q, discard_d;

  logic [CW-1:0]        fifo_count;
  fetch_entry_t         fifo_head;
  fetch_entry_t         fifo_wdata;
  logic [CW:0]          credit_used;
  logic [CPU_WIDTH-1:0] redir_target;
  logic                 accept, rsp_keep, rsp_drop, push, pop;

  assign credit_used  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign redir_target = redirect_pc & ~CPU_WIDTH'(3);

  // Gated by rst so no request is visible while reset is held.
  assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (discard_q != '0);
  assign rsp_keep = imem_rsp_valid && (discard_q == '0);

  assign out_valid = (fifo_count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = rsp_keep && !redirect_valid;
  assign fifo_wdata = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid) begin
      // Everything still in flight, less any response landing now, belongs to the old path.
      fetch_pc_d    = redir_target;
      rsp_pc_d      = redir_target;
      outstanding_d = '0;
      discard_d     = discard_q + DW'(outstanding_q) - DW'(imem_rsp_valid);
    end else begin
      if (accept)   fetch_pc_d = fetch_pc_q + CPU_WIDTH'(4);
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + CPU_WIDTH'(4);
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_keep);
      discard_d     = discard_q - DW'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  kamacore_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (fifo_wdata),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign out_pc    = fifo_head.pc;
  assign out_instr = fifo_head.instr;

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> ((outstanding_q != '0) || (discard_q != '0)));

endmodule

`default_nettype wire

// File: tb/tb_kamacore_fetch_queue.sv
// tb_kamacore_fetch_queue: directed vectors against an in-order imem model and a PC scoreboard.
`default_nettype none

module tb_kamacore_fetch_queue;
  import kamacore_datatypes::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  kamacore_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc, lat_min, lat_max, consumed, accepted, snap;
  bit          rnd_ready;
  logic [31:0] exp_pc;
  logic        s_req_valid, s_out_valid;
  logic [31:0] s_req_addr, s_out_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[31:16] ^ 16'h3C3C};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: drive at posedge+1, sample at the falling edge, advance.
  task automatic run_cycle(input bit redir, input logic [31:0] rpc, input bit ordy);
    mreq_t h;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ordy;
    imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      h = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(h.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #4;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    if (redir) begin
      check_vec("redir_req_valid", 32'(imem_req_valid), 32'd0);
      check_vec("redir_out_valid", 32'(out_valid), 32'd0);
      exp_pc = rpc & ~32'h3;
    end
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
      accepted++;
    end
    if (out_valid && out_ready) begin
      check_vec("out_pc", out_pc, exp_pc);
      check_vec("out_instr", out_instr, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    mq.delete();
    #1;
    check_vec("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_vec("rst_out_valid", 32'(out_valid), 32'd0);
    check_vec("rst_req_addr", imem_req_addr, RESET_PC);
    check_vec("rst_out_pc", out_pc, 32'd0);
    check_vec("rst_out_instr", out_instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    cyc      = 0;
    exp_pc   = RESET_PC;
    consumed = 0;
    accepted = 0;
  endtask

  initial begin
    lat_min = 1; lat_max = 1; rnd_ready = 1'b0;
    cyc = 0;

    // Streaming with 1-cycle memory.
    do_reset();
    run_cycle(0, '0, 1);
    check_vec("c0_req_valid", 32'(s_req_valid), 32'd1);
    check_vec("c0_req_addr", s_req_addr, 32'h0);
    check_vec("c0_out_valid", 32'(s_out_valid), 32'd0);
    run_cycle(0, '0, 1);
    check_vec("c1_req_addr", s_req_addr, 32'h4);
    check_vec("c1_out_valid", 32'(s_out_valid), 32'd0);
    run_cycle(0, '0, 1);
    check_vec("c2_out_valid", 32'(s_out_valid), 32'd1);
    check_vec("c2_out_pc", s_out_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      run_cycle(0, '0, 1);
      check_vec("steady_out_valid", 32'(s_out_valid), 32'd1);
    end
    check_vec("steady_consumed", 32'(consumed), 32'd7);

    // Back-pressure: credits run out at DEPTH.
    do_reset();
    repeat (10) run_cycle(0, '0, 0);
    check_vec("stall_accepted", 32'(accepted), 32'd4);
    check_vec("stall_req_valid", 32'(s_req_valid), 32'd0);
    check_vec("stall_out_valid", 32'(s_out_valid), 32'd1);
    check_vec("stall_head_pc", s_out_pc, 32'h0);
    run_cycle(0, '0, 1);
    check_vec("resume0_req_valid", 32'(s_req_valid), 32'd0);
    run_cycle(0, '0, 1);
    check_vec("resume1_req_valid", 32'(s_req_valid), 32'd1);
    check_vec("resume1_req_addr", s_req_addr, 32'h10);
    repeat (4) run_cycle(0, '0, 1);
    check_vec("resume_consumed", 32'(consumed), 32'd6);

    // Redirect with three stale fetches, 3-cycle memory.
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (3) run_cycle(0, '0, 1);
    run_cycle(1, 32'h0000_0103, 1);
    run_cycle(0, '0, 1);
    check_vec("r1_req_valid", 32'(s_req_valid), 32'd1);
    check_vec("r1_req_addr", s_req_addr, 32'h100);
    run_cycle(0, '0, 1);
    run_cycle(0, '0, 1);
    check_vec("r1_c6_out_valid", 32'(s_out_valid), 32'd0);
    run_cycle(0, '0, 1);
    check_vec("r1_c7_out_valid", 32'(s_out_valid), 32'd0);
    run_cycle(0, '0, 1);
    check_vec("r1_c8_out_valid", 32'(s_out_valid), 32'd1);
    check_vec("r1_c8_out_pc", s_out_pc, 32'h100);
    check_vec("r1_consumed", 32'(consumed), 32'd1);

    // Redirect coinciding with a stale response, then a second redirect.
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (2) run_cycle(0, '0, 1);
    run_cycle(1, 32'h0000_0300, 1);
    run_cycle(1, 32'h0000_0200, 1);
    run_cycle(0, '0, 1);
    check_vec("r2_req_valid", 32'(s_req_valid), 32'd1);
    check_vec("r2_req_addr", s_req_addr, 32'h200);
    check_vec("r2_c4_out_valid", 32'(s_out_valid), 32'd0);
    run_cycle(0, '0, 1);
    run_cycle(0, '0, 1);
    check_vec("r2_c6_out_valid", 32'(s_out_valid), 32'd0);
    run_cycle(0, '0, 1);
    check_vec("r2_c7_out_valid", 32'(s_out_valid), 32'd1);
    check_vec("r2_c7_out_pc", s_out_pc, 32'h200);
    check_vec("r2_consumed", 32'(consumed), 32'd1);

    // Random ready and latency: scoreboard enforces strict +4 order.
    do_reset();
    lat_min = 1; lat_max = 4; rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) run_cycle(0, '0, ($urandom_range(0, 3) != 0));
    check_vec("rand_progress", 32'(consumed > 20), 32'd1);

    // PC wrap at the top of the address space.
    lat_min = 1; lat_max = 1; rnd_ready = 1'b0;
    run_cycle(1, 32'hFFFF_FFFE, 1);
    snap = consumed;
    run_cycle(0, '0, 1);
    check_vec("wrap_req_addr0", s_req_addr, 32'hFFFF_FFFC);
    run_cycle(0, '0, 1);
    check_vec("wrap_req_valid", 32'(s_req_valid), 32'd1);
    check_vec("wrap_req_addr1", s_req_addr, 32'h0000_0000);
    repeat (10) run_cycle(0, '0, 1);
    check_vec("wrap_consumed", 32'((consumed - snap) >= 2), 32'd1);

    // Reset mid-stream, then restart from RESET_PC.
    do_reset();
    run_cycle(0, '0, 1);
    check_vec("post_rst_req_valid", 32'(s_req_valid), 32'd1);
    check_vec("post_rst_req_addr", s_req_addr, RESET_PC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
